// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth product accumulator slice.
package booth_pkg;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int SEXT_MAX   = 64;

  typedef enum logic {
    ACCUM,
    OUTPUT
  } acc_state_e;

  // Sign-extends the low pw bits of p; callers size-cast to ACC_W+1.
  function automatic logic [SEXT_MAX-1:0] sext_prod(
    input logic [SEXT_MAX-1:0] p,
    input int                  pw
  );
    logic [SEXT_MAX-1:0] r;
    for (int i = 0; i < SEXT_MAX; i++) begin
      r[i] = (i < pw) ? p[i] : p[pw-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_product_accumulator_acc_add_sat.sv
// Accumulator adder with overflow detect.
// ACC_SATURATE_EN: clamp on overflow instead of wrapping.
module acc_add_sat
  import booth_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  acc_next,
  output logic              ovf_now
);

  logic [ACC_W:0] pext;
  logic [ACC_W:0] acc_x;
  logic [ACC_W:0] sum_x;

  always_comb begin
    pext    = (ACC_W+1)'(sext_prod(SEXT_MAX'(prod), PROD_W));
    acc_x   = {acc[ACC_W-1], acc};
    sum_x   = acc_x + pext;
    ovf_now = sum_x[ACC_W] ^ sum_x[ACC_W-1];
`ifdef ACC_SATURATE_EN
    // Bit ACC_W carries the sign of the true result.
    if (ovf_now) begin
      acc_next = sum_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                              : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_next = sum_x[ACC_W-1:0];
    end
`else
    acc_next = sum_x[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/booth_product_accumulator.sv
// Block accumulator of signed Booth products with valid/ready output.
// ACC_SATURATE_EN selects clamping in acc_add_sat.
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int PROD_W    = PROD_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int BLOCK_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [ACC_W-1:0]  sum,
  output logic              sum_ovf
);

  localparam int CNT_W = $clog2(BLOCK_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             sum_valid_q, sum_valid_d;
  logic             sum_ovf_q, sum_ovf_d;

  logic [ACC_W-1:0] add_res;
  logic             ovf_now;

  acc_add_sat #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc      (acc_q),
    .prod     (prod),
    .acc_next (add_res),
    .ovf_now  (ovf_now)
  );

  assign prod_ready = (state_q == ACCUM);
  assign sum_valid  = sum_valid_q;
  assign sum        = sum_q;
  assign sum_ovf    = sum_ovf_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
    sum_ovf_d   = sum_ovf_q;
    if (clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      sum_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (prod_valid) begin
            if (cnt_q == LAST) begin
              sum_d       = add_res;
              sum_ovf_d   = ovf_q | ovf_now;
              sum_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              ovf_d       = 1'b0;
              state_d     = OUTPUT;
            end else begin
              acc_d = add_res;
              cnt_d = cnt_q + CNT_W'(1);
              ovf_d = ovf_q | ovf_now;
            end
          end
        end
        OUTPUT: begin
          if (sum_ready) begin
            sum_valid_d = 1'b0;
            state_d     = ACCUM;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      sum_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      sum_ovf_q   <= sum_ovf_d;
    end
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Self-checking bench: default build and ACC_W=9 copies side by side.
module tb_booth_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        prod_valid;
  logic        sum_ready;
  logic [7:0]  prod;

  logic        prod_ready, sum_valid, sum_ovf;
  logic [15:0] sum;
  logic        prod_ready9, sum_valid9, sum_ovf9;
  logic [8:0]  sum9;

  int total = 0;
  int bad   = 0;
  int got16, got9;
  bit gov16, gov9;

  always #5 clk = ~clk;

  booth_product_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod       (prod),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sum        (sum),
    .sum_ovf    (sum_ovf)
  );

  booth_product_accumulator #(.ACC_W(9)) dut9 (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready9),
    .prod       (prod),
    .sum_valid  (sum_valid9),
    .sum_ready  (sum_ready),
    .sum        (sum9),
    .sum_ovf    (sum_ovf9)
  );

  // Reference: exact integer sum of the block, then wrap or clamp.
  function automatic void model(input int vals[$], input int w,
                                output int s, output bit o);
    longint a = 0;
    longint t;
    longint hi = (64'sd1 <<< (w-1)) - 1;
    longint lo = -(64'sd1 <<< (w-1));
    o = 1'b0;
    foreach (vals[i]) begin
      t = a + vals[i];
      if (t > hi || t < lo) begin
        o = 1'b1;
`ifdef ACC_SATURATE_EN
        t = (t > hi) ? hi : lo;
`else
        t = (t > hi) ? t - (64'sd1 <<< w) : t + (64'sd1 <<< w);
`endif
      end
      a = t;
    end
    s = int'(a);
  endfunction

  task automatic send_vals(input int vals[$], input string nm);
    int i = 0;
    int guard = 0;
    bit acc_now;
    while (i < vals.size() && guard < 100) begin
      prod_valid = 1'b1;
      prod = 8'(vals[i]);
      acc_now = prod_ready;
      @(negedge clk);
      guard++;
      if (acc_now) i++;
    end
    prod_valid = 1'b0;
    if (i < vals.size()) begin
      total++;
      bad++;
      $display("FAIL %s timeout accepted=%0d need=%0d", nm, i, vals.size());
    end
  endtask

  task automatic check_sum(input int vals[$], input string nm);
    int s16, s9;
    bit o16, o9;
    model(vals, 16, s16, o16);
    model(vals, 9, s9, o9);
    got16 = $signed(sum);
    got9  = $signed(sum9);
    gov16 = sum_ovf;
    gov9  = sum_ovf9;
    total++;
    if (sum_valid !== 1'b1 || sum_valid9 !== 1'b1) begin
      bad++;
      $display("FAIL %s sum_valid got=%b/%b exp=1", nm, sum_valid, sum_valid9);
    end
    total++;
    if (prod_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s prod_ready_out got=%b exp=0", nm, prod_ready);
    end
    total++;
    if (got16 !== s16 || gov16 !== o16) begin
      bad++;
      $display("FAIL %s sum16 got=%0d/%b exp=%0d/%b", nm, got16, gov16, s16, o16);
    end
    total++;
    if (got9 !== s9 || gov9 !== o9) begin
      bad++;
      $display("FAIL %s sum9 got=%0d/%b exp=%0d/%b", nm, got9, gov9, s9, o9);
    end
  endtask

  task automatic release_sum(input int stall, input string nm);
    logic [15:0] h;
    h = sum;
    sum_ready = (stall == 0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      total++;
      if (sum_valid !== 1'b1 || sum !== h || prod_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s hold got v=%b s=%h r=%b exp v=1 s=%h r=0",
                 nm, sum_valid, sum, prod_ready, h);
      end
    end
    sum_ready = 1'b1;
    @(negedge clk);
    total++;
    if (sum_valid !== 1'b0 || prod_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s release got v=%b r=%b exp v=0 r=1",
               nm, sum_valid, prod_ready);
    end
  endtask

  task automatic do_block(input int vals[$], input int stall, input string nm);
    send_vals(vals, nm);
    check_sum(vals, nm);
    release_sum(stall, nm);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear = 1'b0;
    prod_valid = 1'b0;
    sum_ready = 1'b1;
    prod = '0;
    repeat (2) @(negedge clk);
    total++;
    if (prod_ready !== 1'b1 || sum_valid !== 1'b0 ||
        sum !== 16'h0 || sum_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset got r=%b v=%b s=%h o=%b exp r=1 v=0 s=0 o=0",
               prod_ready, sum_valid, sum, sum_ovf);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_block('{10, -3, 7, 2}, 0, "basic");
    total++;
    if (got16 !== 16 || gov16 !== 1'b0) begin
      bad++;
      $display("FAIL basic_const got=%0d/%b exp=16/0", got16, gov16);
    end
  endtask

  task automatic test_negative();
    do_block('{-56, -56, -56, -56}, 0, "neg");
    total++;
    if (16'(got16) !== 16'hFF20 || gov16 !== 1'b0) begin
      bad++;
      $display("FAIL neg_const got=%h/%b exp=ff20/0", 16'(got16), gov16);
    end
  endtask

  task automatic test_overflow();
    int exp9;
`ifdef ACC_SATURATE_EN
    exp9 = 255;
`else
    exp9 = -131;
`endif
    do_block('{127, 127, 127, 0}, 0, "ovf");
    total++;
    if (got9 !== exp9 || gov9 !== 1'b1) begin
      bad++;
      $display("FAIL ovf_const got=%0d/%b exp=%0d/1", got9, gov9, exp9);
    end
  endtask

  task automatic test_backpressure();
    int nxt[$] = '{-20, 33, 1, -4};
    send_vals('{9, 8, 7, 6}, "bp");
    check_sum('{9, 8, 7, 6}, "bp");
    prod_valid = 1'b1;
    prod = 8'(nxt[0]);
    release_sum(5, "bp");
    do_block(nxt, 0, "bp_next");
  endtask

  task automatic test_clear();
    send_vals('{5, 5}, "clr_part");
    clear = 1'b1;
    prod_valid = 1'b1;
    prod = 8'd99;
    @(negedge clk);
    clear = 1'b0;
    prod_valid = 1'b0;
    do_block('{1, 1, 1, 1}, 0, "clr_part");
    total++;
    if (got16 !== 4) begin
      bad++;
      $display("FAIL clr_const got=%0d exp=4", got16);
    end
    send_vals('{2, 3, 4, 5}, "clr_out");
    check_sum('{2, 3, 4, 5}, "clr_out");
    sum_ready = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    sum_ready = 1'b1;
    total++;
    if (sum_valid !== 1'b0 || prod_ready !== 1'b1) begin
      bad++;
      $display("FAIL clr_drop got v=%b r=%b exp v=0 r=1", sum_valid, prod_ready);
    end
    do_block('{7, 7, 7, 7}, 0, "clr_after");
  endtask

  task automatic async_rst_check(input string nm);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (prod_ready !== 1'b1 || sum_valid !== 1'b0 ||
        sum !== 16'h0 || sum_ovf !== 1'b0) begin
      bad++;
      $display("FAIL %s got r=%b v=%b s=%h o=%b exp r=1 v=0 s=0 o=0",
               nm, prod_ready, sum_valid, sum, sum_ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    send_vals('{3, 4}, "arst_mid");
    async_rst_check("arst_mid");
    do_block('{1, 2, 3, 4}, 0, "arst_mid_next");
    send_vals('{50, 60, 70, 80}, "arst_out");
    sum_ready = 1'b0;
    async_rst_check("arst_out");
    sum_ready = 1'b1;
    do_block('{-1, -2, -3, -4}, 0, "arst_out_next");
  endtask

  task automatic test_random();
    int vals[$];
    for (int b = 0; b < 24; b++) begin
      vals = {};
      for (int k = 0; k < 4; k++) begin
        vals.push_back(int'($urandom_range(0, 255)) - 128);
      end
      do_block(vals, int'($urandom_range(0, 3)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_overflow();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
